// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
//
// Accepts one load/store at a time over a valid/ready handshake, waits
// WAIT_STATES cycles, then commits the access to a word-organised array and
// returns a one-cycle response. Byte/half/word lanes are little-endian.
//
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses
// with resp_err (store suppressed, rdata 0). Without it, misaligned addresses
// are forced aligned and resp_err is tied 0.
//
// Parameters:
//   DEPTH_WORDS  array depth in 32-bit words (power of two, >= 2)
//   WAIT_STATES  cycles spent in WAIT between accept and response (0..15)
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we, req_size      store flag, access size (00 b, 01 h, 1x w)
//   req_sign              sign-extend loads
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid            one-cycle response strobe
//   resp_rdata, resp_err  extended load data, misalignment flag
//   stall                 pipeline freeze while an access is outstanding

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic        cap_we;
  logic [1:0]  cap_size;
  logic        cap_sign;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access commits on the accept edge itself, so
  // the datapath reads the live request in IDLE and the captured copy later.
  logic        eff_we;
  logic [1:0]  eff_size;
  logic        eff_sign;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;

  logic        accept;
  logic        commit;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] next_rdata;
  logic        write_ok;
  logic        next_err;
  logic        unused_addr_bits;

  assign eff_we    = (state == IDLE) ? req_we    : cap_we;
  assign eff_size  = (state == IDLE) ? req_size  : cap_size;
  assign eff_sign  = (state == IDLE) ? req_sign  : cap_sign;
  assign eff_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign eff_wdata = (state == IDLE) ? req_wdata : cap_wdata;

  assign accept = (state == IDLE) && req_valid;
  assign commit = (accept && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && (cnt == 4'd1));

  assign stall = accept || (state == WAIT);

  // Upper address bits are intentionally ignored: accesses wrap.
  assign unused_addr_bits = ^eff_addr[31:AW+2];
  assign idx              = eff_addr[AW+1:2];
  assign rd_word          = mem[idx];

  // Lane offset, forced to the natural alignment of the access size.
  always_comb begin
    lane = eff_addr[1:0];
    if (eff_size == 2'b01) begin
      lane = {eff_addr[1], 1'b0};
    end else if (eff_size[1]) begin
      lane = 2'b00;
    end
  end

  always_comb begin
    be    = 4'hf;
    wlane = eff_wdata;
    case (eff_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << lane;
        wlane = {2{eff_wdata[15:0]}};
      end
      default: begin
        be    = 4'hf;
        wlane = eff_wdata;
      end
    endcase
  end

  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = shifted;
    case (eff_size)
      2'b00:   load_data = {{24{eff_sign & shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = {{16{eff_sign & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;

  assign misalign = ((eff_size == 2'b01) && eff_addr[0]) ||
                    (eff_size[1] && (eff_addr[1:0] != 2'b00));

  always_comb begin
    next_err   = misalign;
    write_ok   = eff_we && !misalign;
    next_rdata = (eff_we || misalign) ? 32'h0 : load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= next_err;
    end
  end

  assign resp_err = err_q;
`else
  always_comb begin
    next_err   = 1'b0;
    write_ok   = eff_we;
    next_rdata = eff_we ? 32'h0 : load_data;
  end

  assign resp_err = next_err;
`endif

  // Array has no reset; only addressed byte lanes are written.
  always_ff @(posedge clk) begin
    if (commit && write_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      cap_we     <= 1'b0;
      cap_size   <= 2'b00;
      cap_sign   <= 1'b0;
      cap_addr   <= 32'h0;
      cap_wdata  <= 32'h0;
    end else begin
      resp_valid <= commit;
      if (commit) begin
        resp_rdata <= next_rdata;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_size  <= req_size;
            cap_sign  <= req_sign;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder

module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour: n-byte access, naturally aligned, little-endian.
  task automatic model(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] exp_rd, output logic exp_err);
    int idx;
    int off;
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    idx = int'((addr >> 2) % DEPTH);
    off = int'(addr % 4);
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_rd  = 32'h0;
    exp_err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((off % n) != 0) begin
      exp_err = 1'b1;
      return;
    end
`endif
    off = off - (off % n);
    if (we) begin
      for (int b = 0; b < n; b++) begin
        ref_mem[idx][8*(off+b) +: 8] = wdata[8*b +: 8];
      end
    end else begin
      v = ref_mem[idx] >> (8 * off);
      if (n < 4) begin
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = v & mask;
        if (sign && v[8*n-1]) v = v | ~mask;
      end
      exp_rd = v;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic access(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    logic [31:0] exp_rd;
    logic        exp_err;
    model(we, size, sign, addr, wdata, exp_rd, exp_err);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    check("stall_accept", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < WS; k++) begin
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_size  = 2'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      check("ready_wait", {31'b0, req_ready}, 32'd0);
      check("stall_wait", {31'b0, stall}, 32'd1);
      check("valid_wait", {31'b0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check("valid_resp", {31'b0, resp_valid}, 32'd1);
    check("stall_resp", {31'b0, stall}, 32'd0);
    check("ready_resp", {31'b0, req_ready}, 32'd0);
    check("rdata", resp_rdata, exp_rd);
    check("err", {31'b0, resp_err}, {31'b0, exp_err});
    rdata = resp_rdata;
    err   = resp_err;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("valid_after", {31'b0, resp_valid}, 32'd0);
    check("ready_after", {31'b0, req_ready}, 32'd1);
    check("rdata_hold", resp_rdata, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) begin
      access(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, rd, er);
    end

    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    check("plan_word", rd, 32'hDEADBEEF);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er);
    check("plan_byte_s", rd, 32'hFFFFFFDE);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er);
    check("plan_byte_u", rd, 32'h000000DE);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er);
    check("plan_half_s", rd, 32'hFFFFDEAD);
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, rd, er);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    check("plan_merge", rd, 32'h1234BEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10 + 4 * DEPTH, 32'h0, rd, er);
    check("plan_wrap", rd, 32'h1234BEEF);

    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, rd, er);
    access(1'b1, 2'b10, 1'b0, 32'h21, 32'h55AA55AA, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("plan_mis_err", {31'b0, er}, 32'd1);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    check("plan_mis_data", rd, 32'h01020304);
`else
    check("plan_mis_err", {31'b0, er}, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    check("plan_mis_data", rd, 32'h55AA55AA);
`endif

    // Reset while a store sits in WAIT: it must never commit.
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'h0, rd, er);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h30;
    req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_in_wait", {31'b0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_ready", {31'b0, req_ready}, 32'd1);
    check("mid_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rdata", resp_rdata, 32'h0);
    check("mid_err", {31'b0, resp_err}, 32'd0);
    check("mid_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("mid_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er);
    check("mid_load", rd, 32'h0);

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
